des_sbox_sched: RTL and testbench

Sequencer that time-shares a reduced bank of DES S-box lookup units to perform the full 48-bit to 32-bit substitution step of the DES round function F.
- Accepts one 48-bit post-key-XOR word per transaction on a valid/ready handshake.
- Walks the eight 6-bit chunks through LANES lookups per cycle.
- Assembles the 32-bit result and presents it on a valid/ready output, with backpressure.
- Sits between the key-mix XOR and the P-permutation in the round datapath.

---
 rtl/des_pkg.sv | 26 ++
 rtl/des_sbox_rom.sv | 34 +++
 rtl/des_sbox_sched.sv | 95 +++++++++
 tb/tb_des_sbox_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants, the S-box sequencer state type and the chunk-index helper.
package des_pkg;

  localparam int NUM_SBOX   = 8;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int DES_HALF_W = 32;
  localparam int DES_EXP_W  = 48;
  localparam int SEL_W      = 3;

  typedef logic [SEL_W-1:0] sbox_sel_t;

  // Chunk 0 (S1) sits in the most significant slot of the packed words.
  localparam sbox_sel_t LAST_SBOX = sbox_sel_t'(NUM_SBOX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  function automatic sbox_sel_t chunk_idx(input int cnt, input int lane, input int lanes);
    return sbox_sel_t'(cnt * lanes + lane);
  endfunction

endpackage

// File: rtl/des_sbox_rom.sv
// Combinational DES S-box lookup, table S1..S8 chosen by i_sel.
// Row = {c[5], c[0]}, column = c[4:1]; each table is stored row-major, entry 0 leftmost.
module des_sbox_rom
  import des_pkg::*;
(
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [SBOX_IN_W-1:0]  i_in,
  output logic [SBOX_OUT_W-1:0] o_out
);

  localparam int TBL_W = 64 * SBOX_OUT_W;

  logic [5:0]       addr;
  logic [TBL_W-1:0] tbl;

  assign addr = {i_in[5], i_in[0], i_in[4:1]};

  always_comb begin
    tbl = '0;
    unique case (i_sel)
      3'd0: tbl = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      3'd1: tbl = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3'd2: tbl = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3'd3: tbl = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      3'd4: tbl = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      3'd5: tbl = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      3'd6: tbl = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: tbl = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
  end

  assign o_out = SBOX_OUT_W'(tbl >> {6'd63 - addr, 2'b00});

endmodule

// File: rtl/des_sbox_sched.sv
// DES 48->32 substitution on LANES shared S-box ROMs; o_valid rises NUM_SBOX/LANES cycles after accept.
// Result is held in DONE until i_ready; o_ready follows i_ready there so words can run back to back.
module des_sbox_sched
  import des_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DES_EXP_W-1:0]  i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DES_HALF_W-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int STEPS = NUM_SBOX / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("des_sbox_sched: LANES must be 1, 2, 4 or 8");
  end

  sched_state_t                         state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [NUM_SBOX-1:0][SBOX_IN_W-1:0]   data_q, data_d;
  logic [NUM_SBOX-1:0][SBOX_OUT_W-1:0]  res_q, res_d;
  sbox_sel_t                            lane_idx [LANES];
  logic [SBOX_OUT_W-1:0]                lane_out [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_idx[j] = chunk_idx(int'(cnt_q), j, LANES);
    des_sbox_rom u_rom (
      .i_sel (lane_idx[j]),
      .i_in  (data_q[LAST_SBOX - lane_idx[j]]),
      .o_out (lane_out[j])
    );
  end

  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_data  = res_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    res_d   = res_q;
    o_ready = 1'b0;
    unique case (state_q)
      IDLE: o_ready = 1'b1;
      RUN: begin
        for (int j = 0; j < LANES; j++) begin
          res_d[LAST_SBOX - lane_idx[j]] = lane_out[j];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        o_ready = i_ready;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A capture in DONE overrides the return to IDLE: output and input handshake share the edge.
    if (i_valid && o_ready) begin
      data_d  = i_data;
      res_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_des_sbox_sched.sv
// Bench for des_sbox_sched: directed latency/backpressure/back-to-back scenarios on LANES=1,2,8
// plus a randomized valid/ready run on LANES=2 scored against a table-driven DES S-layer model.
module tb_des_sbox_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] i_data;
  logic        i_valid;
  logic        i_ready;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_data;
  logic        o_ready1, o_valid1, o_busy1;
  logic [31:0] o_data1;
  logic        o_ready8, o_valid8, o_busy8;
  logic [31:0] o_data8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_sbox_sched #(.LANES(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy));
  des_sbox_sched #(.LANES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready1),
    .o_data(o_data1), .o_valid(o_valid1), .i_ready(i_ready), .o_busy(o_busy1));
  des_sbox_sched #(.LANES(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready8),
    .o_data(o_data8), .o_valid(o_valid8), .i_ready(i_ready), .o_busy(o_busy8));

  // FIPS 46-3 S-boxes, SB[box][row*16 + col].
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [31:0] r;
    logic [5:0]  c;
    int          row, col;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      c   = 6'(x >> (42 - 6 * k));
      row = 2 * int'(c[5]) + int'(c[0]);
      col = int'(c[4:1]);
      r   = (r << 4) | 32'(SB[k][row * 16 + col]);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    do_reset(2);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", o_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", o_ready); end
    // Start a word, abort it two cycles into RUN with a 3-cycle reset.
    i_ready = 1'b1; i_valid = 1'b1; i_data = 48'h0;
    tick();
    i_valid = 1'b0;
    tick();
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy: got %b want 1", o_busy); end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL abort_data: got %h want 0", o_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", o_ready); end
    n_cmp++; if ({o_busy1, o_busy8, o_ready1, o_ready8} !== 4'b0011) begin
      n_err++; $display("FAIL abort_l1l8_state: got %b want 0011", {o_busy1, o_busy8, o_ready1, o_ready8}); end
    n_cmp++; if (o_data8 !== 32'h0) begin n_err++; $display("FAIL abort_l8_data: got %h want 0", o_data8); end
    seen = 0;
    repeat (12) begin
      tick();
      if (o_valid || o_valid1 || o_valid8) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_output: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_single(input logic [47:0] d, input logic [31:0] exp);
    int lat1, lat2, lat8;
    logic [31:0] d1, d2, d8;
    lat1 = -1; lat2 = -1; lat8 = -1; d1 = '0; d2 = '0; d8 = '0;
    i_ready = 1'b1; i_data = d; i_valid = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) begin
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", o_busy); end
      end
      if (lat2 < 0 && o_valid)  begin lat2 = cyc; d2 = o_data;  end
      if (lat1 < 0 && o_valid1) begin lat1 = cyc; d1 = o_data1; end
      if (lat8 < 0 && o_valid8) begin lat8 = cyc; d8 = o_data8; end
    end
    n_cmp++; if (lat2 !== 4) begin n_err++; $display("FAIL lat_l2: got %0d want 4", lat2); end
    n_cmp++; if (lat1 !== 8) begin n_err++; $display("FAIL lat_l1: got %0d want 8", lat1); end
    n_cmp++; if (lat8 !== 1) begin n_err++; $display("FAIL lat_l8: got %0d want 1", lat8); end
    n_cmp++; if (d2 !== exp) begin n_err++; $display("FAIL data_l2: got %h want %h", d2, exp); end
    n_cmp++; if (d1 !== exp) begin n_err++; $display("FAIL data_l1: got %h want %h", d1, exp); end
    n_cmp++; if (d8 !== exp) begin n_err++; $display("FAIL data_l8: got %h want %h", d8, exp); end
  endtask

  task automatic test_backpressure();
    logic [47:0] d;
    logic [31:0] exp;
    int seen;
    d = {16'($urandom), 32'($urandom)};
    exp = sbox_layer(d);
    i_ready = 1'b0; i_data = d; i_valid = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_idle: got %b want 1", o_ready); end
    tick();
    i_data = {16'($urandom), 32'($urandom)};
    repeat (3) tick();
    for (int n = 0; n < 5; n++) begin
      tick();
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", n, o_valid); end
      n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", n, o_data, exp); end
      n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", n, o_ready); end
      n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL bp_busy[%0d]: got %b want 1", n, o_busy); end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_release: got %b want 1", o_ready); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL bp_after_busy: got %b want 0", o_busy); end
    seen = 0;
    repeat (10) begin
      tick();
      if (o_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL bp_not_consumed: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, nout;
    logic [31:0] d1, d2;
    logic rdy1, drop;
    t1 = -1; t2 = -1; nout = 0; d1 = '0; d2 = '0; rdy1 = 1'b0; drop = 1'b0;
    i_ready = 1'b1; i_data = 48'h0; i_valid = 1'b1;
    tick();
    i_data = 48'hFFFF_FFFF_FFFF;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (drop) begin i_valid = 1'b0; drop = 1'b0; end
      if (o_valid) begin
        nout++;
        if (nout == 1) begin t1 = cyc; d1 = o_data; rdy1 = o_ready; drop = 1'b1; end
        if (nout == 2) begin t2 = cyc; d2 = o_data; end
      end
    end
    n_cmp++; if (t1 !== 4) begin n_err++; $display("FAIL b2b_t1: got %0d want 4", t1); end
    n_cmp++; if (d1 !== 32'hEFA72C4D) begin n_err++; $display("FAIL b2b_d1: got %h want EFA72C4D", d1); end
    n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL b2b_accept_at_handshake: got %b want 1", rdy1); end
    n_cmp++; if (t2 !== 9) begin n_err++; $display("FAIL b2b_t2: got %0d want 9", t2); end
    n_cmp++; if (d2 !== 32'hD9CE3DCB) begin n_err++; $display("FAIL b2b_d2: got %h want D9CE3DCB", d2); end
    n_cmp++; if (d2[3:0] !== 4'hB) begin n_err++; $display("FAIL b2b_s8_nibble: got %h want B", d2[3:0]); end
    n_cmp++; if (nout !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", nout); end
  endtask

  task automatic test_random();
    localparam int N = 1000;
    logic [31:0] q[$];
    logic [31:0] exp;
    int nsent, nrecv, ticks;
    logic acc;
    nsent = 0; nrecv = 0; ticks = 0;
    do_reset(2);
    while (nrecv < N && ticks < 40000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid && nsent < N && $urandom_range(0, 1) == 1) begin
        i_valid = 1'b1;
        i_data  = {16'($urandom), 32'($urandom)};
      end
      #1;
      if (o_valid && i_ready) begin
        nrecv++;
        if (q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rand_extra_output: got %h want none", o_data);
        end else begin
          exp = q.pop_front();
          n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", nrecv, o_data, exp); end
        end
      end
      acc = i_valid && o_ready;
      if (acc) begin
        q.push_back(sbox_layer(i_data));
        nsent++;
      end
      tick();
      ticks++;
      if (acc) i_valid = 1'b0;
    end
    n_cmp++; if (nrecv !== N) begin n_err++; $display("FAIL rand_recv_count: got %0d want %0d", nrecv, N); end
    n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL rand_leftover: got %0d want 0", q.size()); end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    test_reset();
    test_single(48'h0, 32'hEFA72C4D);
    test_single(48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
